// File: rtl/batch_sequencer.sv
// Batch lifecycle sequencer: counts accepted transactions, closes batches on size/timeout/flush.
// Define BATCH_SEQ_STATS_EN to build the saturating close-cause counters.
module batch_sequencer #(
  parameter int MAX_BATCH_SIZE       = 8,
  parameter int BATCH_TIMEOUT_CYCLES = 100,
  localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             txn_accept,
  output logic             txn_ready,
  input  logic             flush_req,
  output logic             batch_valid,
  input  logic             batch_ready,
  output logic [CNT_W-1:0] batch_size,
  output logic [15:0]      batch_id,
  output logic             dep_clear,
  output logic             proto_err,
  output logic [31:0]      batches_by_size,
  output logic [31:0]      batches_by_timeout,
  output logic [31:0]      batches_by_flush
);

  localparam int TMR_W = $clog2(BATCH_TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CLOSE,
    S_CLEAR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_size;
  logic [TMR_W-1:0] r_timer;
  logic [15:0]      r_id;
  logic             r_valid;
  logic             r_dclr;
  logic             r_perr;

  logic             w_ready;
  logic             w_fill;
  logic [CNT_W-1:0] w_size_nxt;
  logic             w_hit_size;
  logic             w_hit_tmo;
  logic             w_cause_size;
  logic             w_cause_tmo;
  logic             w_cause_fl;
  logic             w_close;

  assign w_ready = (r_state == S_IDLE) ||
                   (r_state == S_FILL);
  assign w_fill  = (r_state == S_FILL);

  // r_size is 0 in IDLE, so one adder covers both open states
  assign w_size_nxt = r_size + CNT_W'(txn_accept);
  assign w_hit_size = (w_size_nxt == CNT_W'(MAX_BATCH_SIZE));
  assign w_hit_tmo  = (r_timer == TMR_W'(BATCH_TIMEOUT_CYCLES - 1));

  assign w_cause_size = w_ready && txn_accept && w_hit_size;
  assign w_cause_tmo  = w_fill && w_hit_tmo && !w_cause_size;
  assign w_cause_fl   = w_fill && flush_req &&
                        !w_cause_size && !w_hit_tmo;
  assign w_close      = w_cause_size || w_cause_tmo ||
                        w_cause_fl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_size  <= '0;
      r_timer <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_dclr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (txn_accept && !w_ready) begin
        r_perr <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (txn_accept) begin
            r_size  <= CNT_W'(1);
            r_timer <= '0;
            r_valid <= w_close;
            r_state <= w_close ? S_CLOSE : S_FILL;
          end
        end
        S_FILL: begin
          r_size  <= w_size_nxt;
          r_timer <= r_timer + TMR_W'(1);
          if (w_close) begin
            r_valid <= 1'b1;
            r_state <= S_CLOSE;
          end
        end
        S_CLOSE: begin
          if (batch_ready) begin
            r_valid <= 1'b0;
            r_dclr  <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_dclr  <= 1'b0;
          r_id    <= r_id + 16'd1;
          r_size  <= '0;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign txn_ready   = w_ready;
  assign batch_valid = r_valid;
  assign batch_size  = r_size;
  assign batch_id    = r_id;
  assign dep_clear   = r_dclr;
  assign proto_err   = r_perr;

`ifdef BATCH_SEQ_STATS_EN
  logic [31:0] r_by_size;
  logic [31:0] r_by_tmo;
  logic [31:0] r_by_fl;

  // saturating: hold at all-ones rather than wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_by_size <= '0;
      r_by_tmo  <= '0;
      r_by_fl   <= '0;
    end else begin
      if (w_cause_size && (r_by_size != '1)) begin
        r_by_size <= r_by_size + 32'd1;
      end
      if (w_cause_tmo && (r_by_tmo != '1)) begin
        r_by_tmo <= r_by_tmo + 32'd1;
      end
      if (w_cause_fl && (r_by_fl != '1)) begin
        r_by_fl <= r_by_fl + 32'd1;
      end
    end
  end

  assign batches_by_size    = r_by_size;
  assign batches_by_timeout = r_by_tmo;
  assign batches_by_flush   = r_by_fl;
`else
  assign batches_by_size    = 32'd0;
  assign batches_by_timeout = 32'd0;
  assign batches_by_flush   = 32'd0;
`endif

endmodule
